// File: rtl/niosduino_core_mem_pkg.sv
// rtl/niosduino_core_mem_pkg.sv - shared types and default widths for the on-chip memory arbiter
package niosduino_core_mem_pkg;

    localparam int DEF_ADDR_W = 13;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_DEPTH  = 8192;

    typedef enum logic [1:0] {
        CLR_IDLE  = 2'd0,
        CLR_CLEAR = 2'd1,
        CLR_DONE  = 2'd2
    } clr_state_e;

endpackage

// File: rtl/niosduino_core_rr_arb2.sv
// rtl/niosduino_core_rr_arb2.sv - two-way round-robin grant selection
module niosduino_core_rr_arb2 (
    input  logic [1:0] req_i,
    input  logic       last_grant_i,
    output logic [1:0] grant_o
);

    // On a tie the requester that did not win last time is chosen.
    always_comb begin
        grant_o = req_i;
        if (req_i == 2'b11) begin
            grant_o = last_grant_i ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/niosduino_core_onchip_mem_arbiter.sv
// rtl/niosduino_core_onchip_mem_arbiter.sv - two-master arbiter and zero-fill sequencer for a 1-cycle RAM
module niosduino_core_onchip_mem_arbiter
    import niosduino_core_mem_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [ADDR_W-1:0]   m0_address,
    input  logic [DATA_W/8-1:0] m0_byteenable,
    input  logic                m0_read,
    input  logic                m0_write,
    input  logic [DATA_W-1:0]   m0_writedata,
    output logic [DATA_W-1:0]   m0_readdata,
    output logic                m0_readdatavalid,
    output logic                m0_waitrequest,
    input  logic [ADDR_W-1:0]   m1_address,
    input  logic [DATA_W/8-1:0] m1_byteenable,
    input  logic                m1_read,
    input  logic                m1_write,
    input  logic [DATA_W-1:0]   m1_writedata,
    output logic [DATA_W-1:0]   m1_readdata,
    output logic                m1_readdatavalid,
    output logic                m1_waitrequest,
    input  logic                clear_req,
    output logic                clear_busy,
    output logic                clear_done,
    output logic [ADDR_W-1:0]   mem_address,
    output logic [DATA_W/8-1:0] mem_byteenable,
    output logic                mem_chipselect,
    output logic                mem_write,
    output logic [DATA_W-1:0]   mem_writedata,
    output logic                mem_clken,
    input  logic [DATA_W-1:0]   mem_readdata
);

    localparam logic [ADDR_W-1:0] CNT_LAST = ADDR_W'(DEPTH - 1);

    clr_state_e        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              last_grant_q, last_grant_d;
    logic              rd_pend_q, rd_pend_d;
    logic              rd_owner_q, rd_owner_d;

    logic [1:0] req;
    logic [1:0] grant;
    logic       granted;
    logic       grant_write;

    // Arbitration is only open while the sequencer is idle.
    assign req = {m1_read | m1_write, m0_read | m0_write} & {2{state_q == CLR_IDLE}};

    niosduino_core_rr_arb2 u_rr_arb2 (
        .req_i        (req),
        .last_grant_i (last_grant_q),
        .grant_o      (grant)
    );

    assign granted        = |grant;
    assign grant_write    = grant[1] ? m1_write : m0_write;
    assign m0_waitrequest = ~grant[0];
    assign m1_waitrequest = ~grant[1];

    assign m0_readdata      = mem_readdata;
    assign m1_readdata      = mem_readdata;
    assign m0_readdatavalid = rd_pend_q & ~rd_owner_q;
    assign m1_readdatavalid = rd_pend_q & rd_owner_q;
    assign mem_clken        = 1'b1;

    always_comb begin
        mem_address    = '0;
        mem_byteenable = '0;
        mem_writedata  = '0;
        mem_chipselect = 1'b0;
        mem_write      = 1'b0;
        if (state_q == CLR_CLEAR) begin
            mem_address    = cnt_q;
            mem_byteenable = '1;
            mem_chipselect = 1'b1;
            mem_write      = 1'b1;
        end else if (grant[0]) begin
            mem_address    = m0_address;
            mem_byteenable = m0_byteenable;
            mem_writedata  = m0_writedata;
            mem_chipselect = 1'b1;
            mem_write      = m0_write;
        end else if (grant[1]) begin
            mem_address    = m1_address;
            mem_byteenable = m1_byteenable;
            mem_writedata  = m1_writedata;
            mem_chipselect = 1'b1;
            mem_write      = m1_write;
        end
    end

    always_comb begin
        last_grant_d = granted ? grant[1] : last_grant_q;
        rd_pend_d    = granted & ~grant_write;
        rd_owner_d   = grant[1];
    end

    // Counter holds at the last address instead of wrapping.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        clear_busy = 1'b0;
        clear_done = 1'b0;
        case (state_q)
            CLR_IDLE: begin
                if (clear_req) begin
                    state_d = CLR_CLEAR;
                    cnt_d   = '0;
                end
            end
            CLR_CLEAR: begin
                clear_busy = 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = CLR_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            CLR_DONE: begin
                clear_busy = 1'b1;
                clear_done = 1'b1;
                state_d    = CLR_IDLE;
            end
            default: state_d = CLR_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= CLR_IDLE;
            cnt_q        <= '0;
            last_grant_q <= 1'b1;
            rd_pend_q    <= 1'b0;
            rd_owner_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            rd_pend_q    <= rd_pend_d;
            rd_owner_q   <= rd_owner_d;
        end
    end

endmodule

// File: doc/niosduino_core_onchip_mem_arbiter.md
NIOSDUINO_CORE_ONCHIP_MEM_ARBITER -- requirements
Module: niosduino_core_onchip_mem_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 13, word address width; DATA_W, default 32, data width; DEPTH, default 8192, words cleared by the clear sequencer.
REQ-002 Ports SHALL be:
 clk  in  1  single clock, all logic rising-edge
 reset_n  in  1  asynchronous, active-low reset
 m0_address / m1_address  in  ADDR_W  requester word address
 m0_byteenable / m1_byteenable  in  DATA_W/8  byte lanes
 m0_read, m0_write / m1_read, m1_write  in  1  request strobes
 m0_writedata / m1_writedata  in  DATA_W  write data
 m0_readdata / m1_readdata  out  DATA_W  read data
 m0_readdatavalid / m1_readdatavalid  out  1  read data qualifier
 m0_waitrequest / m1_waitrequest  out  1  request not accepted this cycle
 clear_req  in  1  start zero-fill of memory
 clear_busy  out  1  sequencer active
 clear_done  out  1  one-cycle completion pulse
 mem_address  out  ADDR_W  to RAM address
 mem_byteenable  out  DATA_W/8  to RAM byteenable
 mem_chipselect, mem_write  out  1  to RAM
 mem_writedata  out  DATA_W  to RAM data
 mem_clken  out  1  to RAM clock enable
 mem_readdata  in  DATA_W  from RAM, valid one cycle after address
REQ-003 Clock SHALL be one clock, clk; reset SHALL be reset_n, asynchronous assert, active-low.

Function
REQ-004 Arbitration SHALL be combinational in the request cycle: mN_waitrequest = NOT granted(N); one grant per cycle maximum.
REQ-005 A requester has a request when read OR write is high; read AND write together SHALL be treated as write.
REQ-006 Single requester SHALL be granted immediately; both requesting SHALL grant the one not in register last_grant (round-robin).
REQ-007 last_grant SHALL update to the granted index at each grant clock edge; unchanged when no grant.
REQ-008 Granted requester's address, byteenable, writedata SHALL drive mem_*; mem_chipselect=1; mem_write=granted write; no grant: mem_chipselect=0, mem_write=0.
REQ-009 mem_clken SHALL be constant 1.
REQ-010 Read latency SHALL be exactly 1: grant of read in cycle N -> owner's readdatavalid=1 in cycle N+1 with readdata=mem_readdata; register rd_pend/rd_owner track this.
REQ-011 Back-to-back grants SHALL be allowed every cycle, including alternating owners; no bubbles.
REQ-012 Writes SHALL produce no response.
REQ-013 mN_readdata SHALL equal mem_readdata at all times; only readdatavalid is steered.
REQ-014 Clear FSM states: IDLE, CLEAR, DONE. IDLE->CLEAR when clear_req=1 at clock edge (counter loaded 0); CLEAR writes data 0, byteenable all ones, address=counter, one word per cycle; CLEAR->DONE after counter=DEPTH-1 write; DONE->IDLE unconditionally after one cycle.
REQ-015 clear_busy=1 in CLEAR and DONE; clear_done=1 only in DONE.
REQ-016 In CLEAR and DONE no grant SHALL be issued (both waitrequest=1); clear_req outside IDLE SHALL be ignored.
REQ-017 In the IDLE cycle sampling clear_req, arbitration SHALL proceed normally; a read granted then SHALL complete in the first CLEAR cycle.
REQ-018 Counter SHALL be ADDR_W bits and not wrap past DEPTH-1.

Reset
REQ-019 While reset_n=0: state=IDLE, counter=0, last_grant=1 (m0 wins first tie), rd_pend=0; outputs readdatavalid=0, clear_busy=0, clear_done=0; waitrequest follows REQ-004 with state IDLE.
REQ-020 Reset mid-CLEAR SHALL abort the sequence with no clear_done; reset with rd_pend=1 SHALL drop the pending response.

Structure
REQ-021 FSM state enum and default widths SHALL live in shared package niosduino_core_mem_pkg.
REQ-022 Round-robin selection SHALL be sub-module niosduino_core_rr_arb2 (two requests, last_grant in, grant one-hot out); the rest stays flat.

Verification
REQ-023 m0 read addr 0x0005 alone -> waitrequest0=0 same cycle, readdatavalid0=1 next cycle with RAM word 5.
REQ-024 m0 and m1 reading continuously from reset -> grants m0,m1,m0,m1...; each readdatavalid one cycle after its grant.
REQ-025 m1 write 0xDEADBEEF addr 0x1FFF byteenable 0x3 while m0 idle -> RAM word holds 0x????BEEF, no readdatavalid.
REQ-026 clear_req pulse with m0 read granted same cycle -> m0 readdatavalid next cycle, then 8192 zero writes addr 0..0x1FFF, clear_done one cycle, both waitrequest=1 throughout; all words read 0.
REQ-027 reset_n low at counter 0x0100 -> clear_busy=0 immediately, no clear_done, next tie grants m0.
